// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, T-step states,
// opcode classes, ALU op select and the strobe bundle driven into the datapath.
package control_sequencer_pkg;

   localparam int OPCODE_W = 5;

   localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
   localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10100;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RST,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_T7,
      S_HALT
   } state_t;

   // Bit positions inside the one-hot opcode class vector.
   localparam int CL_LD   = 0;
   localparam int CL_LDI  = 1;
   localparam int CL_ST   = 2;
   localparam int CL_ALU  = 3;
   localparam int CL_ADDI = 4;
   localparam int CL_BR   = 5;
   localparam int CL_JR   = 6;
   localparam int CL_NOP  = 7;
   localparam int CL_HALT = 8;
   localparam int N_CLASS = 9;

   typedef logic [N_CLASS-1:0] op_class_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_t;

   typedef struct packed {
      logic PCout;
      logic PCin;
      logic IncPC;
      logic MARin;
      logic MDRin;
      logic MDRout;
      logic Read;
      logic Write;
      logic IRin;
      logic Yin;
      logic Zin;
      logic Zlowout;
      logic Cout;
      logic BAout;
      logic ADD;
      logic SUB;
      logic AND;
      logic OR;
      logic Gra;
      logic Grb;
      logic Grc;
      logic Rin;
      logic Rout;
      logic CONin;
   } strobes_t;

   // One-hot {OR, AND, SUB, ADD} for a given ALU op.
   function automatic logic [3:0] alu_sel(input alu_op_t op);
      return 4'b0001 << op;
   endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational opcode classifier: one-hot instruction class plus ALU op.
// Anything not recognised is treated as a nop.
module opcode_class_decode
   import control_sequencer_pkg::*;
#(
   parameter int OPW = 5
) (
   input  logic [OPW-1:0] opcode_i,
   output op_class_t      cls_o,
   output alu_op_t        alu_op_o
);

   always_comb begin
      cls_o    = '0;
      alu_op_o = ALU_ADD;
      case (opcode_i)
         OPW'(OP_LD):   cls_o[CL_LD]   = 1'b1;
         OPW'(OP_LDI):  cls_o[CL_LDI]  = 1'b1;
         OPW'(OP_ST):   cls_o[CL_ST]   = 1'b1;
         OPW'(OP_ADD):  cls_o[CL_ALU]  = 1'b1;
         OPW'(OP_SUB): begin
            cls_o[CL_ALU] = 1'b1;
            alu_op_o      = ALU_SUB;
         end
         OPW'(OP_AND): begin
            cls_o[CL_ALU] = 1'b1;
            alu_op_o      = ALU_AND;
         end
         OPW'(OP_OR): begin
            cls_o[CL_ALU] = 1'b1;
            alu_op_o      = ALU_OR;
         end
         OPW'(OP_ADDI): cls_o[CL_ADDI] = 1'b1;
         OPW'(OP_BR):   cls_o[CL_BR]   = 1'b1;
         OPW'(OP_JR):   cls_o[CL_JR]   = 1'b1;
         OPW'(OP_HALT): cls_o[CL_HALT] = 1'b1;
         default:       cls_o[CL_NOP]  = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-step control unit: fetch T0-T2, class-dependent execute T3-T7,
// with Moore strobe decode driving the datapath control inputs one-to-one.
//
// state  | meaning
// S_RST  | in reset, all strobes low, run low
// S_T0   | fetch: PC to MAR, increment PC into Z
// S_T1   | fetch: Z to PC, memory read into MDR
// S_T2   | fetch: MDR to IR
// S_T3-7 | execute steps, content set by opcode class
// S_HALT | stopped until reset, all strobes low, run low
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int OPW = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ir,
   input  logic        con_ff,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        Write,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Cout,
   output logic        BAout,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        CONin,
   output logic        run
);

   state_t    state_q, state_d;
   op_class_t cls;
   alu_op_t   alu_op;
   strobes_t  s;
   logic      unused_ir_bits;

   logic is_ld, is_ldi, is_st, is_alu, is_addi, is_br, is_jr, is_halt;

   opcode_class_decode #(.OPW(OPW)) u_decode (
      .opcode_i (ir[31 -: OPW]),
      .cls_o    (cls),
      .alu_op_o (alu_op)
   );

   assign unused_ir_bits = ^ir[31-OPW:0];

   assign is_ld   = cls[CL_LD];
   assign is_ldi  = cls[CL_LDI];
   assign is_st   = cls[CL_ST];
   assign is_alu  = cls[CL_ALU];
   assign is_addi = cls[CL_ADDI];
   assign is_br   = cls[CL_BR];
   assign is_jr   = cls[CL_JR];
   assign is_halt = cls[CL_HALT];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RST;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST: state_d = S_T0;
         S_T0:  state_d = S_T1;
         S_T1:  state_d = S_T2;
         S_T2:  state_d = S_T3;
         S_T3: begin
            if (is_halt) begin
               state_d = S_HALT;
            end else if (is_ld || is_ldi || is_st || is_alu || is_addi || is_br) begin
               state_d = S_T4;
            end else begin
               state_d = S_T0;
            end
         end
         S_T4:  state_d = S_T5;
         S_T5:  state_d = (is_ld || is_st || is_br) ? S_T6 : S_T0;
         S_T6:  state_d = is_br ? S_T0 : S_T7;
         S_T7:  state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   always_comb begin
      s = '0;
      case (state_q)
         S_T0: begin
            s.PCout = 1'b1;
            s.MARin = 1'b1;
            s.IncPC = 1'b1;
            s.Zin   = 1'b1;
         end
         S_T1: begin
            s.Zlowout = 1'b1;
            s.PCin    = 1'b1;
            s.Read    = 1'b1;
            s.MDRin   = 1'b1;
         end
         S_T2: begin
            s.MDRout = 1'b1;
            s.IRin   = 1'b1;
         end
         S_T3: begin
            if (is_ld || is_ldi || is_st) begin
               s.Grb   = 1'b1;
               s.BAout = 1'b1;
               s.Yin   = 1'b1;
            end else if (is_alu || is_addi) begin
               s.Grb  = 1'b1;
               s.Rout = 1'b1;
               s.Yin  = 1'b1;
            end else if (is_br) begin
               s.Gra   = 1'b1;
               s.Rout  = 1'b1;
               s.CONin = 1'b1;
            end else if (is_jr) begin
               s.Gra  = 1'b1;
               s.Rout = 1'b1;
               s.PCin = 1'b1;
            end
         end
         S_T4: begin
            if (is_alu) begin
               s.Grc = 1'b1;
               s.Rout = 1'b1;
               s.Zin = 1'b1;
               {s.OR, s.AND, s.SUB, s.ADD} = alu_sel(alu_op);
            end else if (is_ld || is_ldi || is_st || is_addi) begin
               s.Cout = 1'b1;
               s.ADD  = 1'b1;
               s.Zin  = 1'b1;
            end else if (is_br) begin
               s.PCout = 1'b1;
               s.Yin   = 1'b1;
            end
         end
         S_T5: begin
            if (is_ld || is_st) begin
               s.Zlowout = 1'b1;
               s.MARin   = 1'b1;
            end else if (is_ldi || is_alu || is_addi) begin
               s.Zlowout = 1'b1;
               s.Gra     = 1'b1;
               s.Rin     = 1'b1;
            end else if (is_br) begin
               s.Cout = 1'b1;
               s.ADD  = 1'b1;
               s.Zin  = 1'b1;
            end
         end
         S_T6: begin
            if (is_ld) begin
               s.Read  = 1'b1;
               s.MDRin = 1'b1;
            end else if (is_st) begin
               s.Gra   = 1'b1;
               s.Rout  = 1'b1;
               s.MDRin = 1'b1;
            end else if (is_br) begin
               // Branch target is committed only when the condition was met in T3.
               s.Zlowout = 1'b1;
               s.PCin    = con_ff;
            end
         end
         S_T7: begin
            if (is_ld) begin
               s.MDRout = 1'b1;
               s.Gra    = 1'b1;
               s.Rin    = 1'b1;
            end else if (is_st) begin
               s.Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign run = (state_q != S_RST) && (state_q != S_HALT);

   assign PCout   = s.PCout;
   assign PCin    = s.PCin;
   assign IncPC   = s.IncPC;
   assign MARin   = s.MARin;
   assign MDRin   = s.MDRin;
   assign MDRout  = s.MDRout;
   assign Read    = s.Read;
   assign Write   = s.Write;
   assign IRin    = s.IRin;
   assign Yin     = s.Yin;
   assign Zin     = s.Zin;
   assign Zlowout = s.Zlowout;
   assign Cout    = s.Cout;
   assign BAout   = s.BAout;
   assign ADD     = s.ADD;
   assign SUB     = s.SUB;
   assign AND     = s.AND;
   assign OR      = s.OR;
   assign Gra     = s.Gra;
   assign Grb     = s.Grb;
   assign Grc     = s.Grc;
   assign Rin     = s.Rin;
   assign Rout    = s.Rout;
   assign CONin   = s.CONin;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: expected strobes per T-step come from a table of
// strobe-name strings per opcode, turned into a bit vector by name lookup.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ir = '0;
   logic        con_ff = 1'b0;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
   logic Yin, Zin, Zlowout, Cout, BAout, ADD, SUB, AND, OR;
   logic Gra, Grb, Grc, Rin, Rout, CONin, run;

   int n_total = 0;
   int n_pass  = 0;

   string names [25] = '{"PCout", "PCin", "IncPC", "MARin", "MDRin", "MDRout",
                         "Read", "Write", "IRin", "Yin", "Zin", "Zlowout", "Cout",
                         "BAout", "ADD", "SUB", "AND", "OR", "Gra", "Grb", "Grc",
                         "Rin", "Rout", "CONin", "run"};
   string seq[$];

   control_sequencer dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .con_ff(con_ff),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
      .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .BAout(BAout), .ADD(ADD),
      .SUB(SUB), .AND(AND), .OR(OR), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .CONin(CONin), .run(run)
   );

   always #5 clk = ~clk;

   function automatic logic [24:0] observed();
      return {run, CONin, Rout, Rin, Grc, Grb, Gra, OR, AND, SUB, ADD, BAout,
              Cout, Zlowout, Zin, Yin, IRin, Write, Read, MDRout, MDRin, MARin,
              IncPC, PCin, PCout};
   endfunction

   function automatic logic [24:0] bit_of(string tok);
      for (int k = 0; k < 25; k++) begin
         if (names[k] == tok) return 25'(1) << k;
      end
      return '0;
   endfunction

   function automatic logic [24:0] mask_of(string s);
      logic [24:0] m = '0;
      int st = 0;
      for (int i = 0; i <= s.len(); i++) begin
         if (i == s.len() || s.getc(i) == " ") begin
            if (i > st) m |= bit_of(s.substr(st, i - 1));
            st = i + 1;
         end
      end
      return m;
   endfunction

   // Whole-instruction strobe script: fetch steps then the execute steps for the opcode.
   function automatic void build_seq(logic [4:0] opc, bit con);
      seq = {"PCout MARin IncPC Zin", "Zlowout PCin Read MDRin", "MDRout IRin"};
      case (opc)
         5'b00000: seq = {seq, "Grb BAout Yin", "Cout ADD Zin", "Zlowout MARin",
                          "Read MDRin", "MDRout Gra Rin"};
         5'b00001: seq = {seq, "Grb BAout Yin", "Cout ADD Zin", "Zlowout Gra Rin"};
         5'b00010: seq = {seq, "Grb BAout Yin", "Cout ADD Zin", "Zlowout MARin",
                          "Gra Rout MDRin", "Write"};
         5'b00011: seq = {seq, "Grb Rout Yin", "Grc Rout ADD Zin", "Zlowout Gra Rin"};
         5'b00100: seq = {seq, "Grb Rout Yin", "Grc Rout SUB Zin", "Zlowout Gra Rin"};
         5'b00101: seq = {seq, "Grb Rout Yin", "Grc Rout AND Zin", "Zlowout Gra Rin"};
         5'b00110: seq = {seq, "Grb Rout Yin", "Grc Rout OR Zin", "Zlowout Gra Rin"};
         5'b01100: seq = {seq, "Grb Rout Yin", "Cout ADD Zin", "Zlowout Gra Rin"};
         5'b10010: seq = {seq, "Gra Rout CONin", "PCout Yin", "Cout ADD Zin",
                          con ? "Zlowout PCin" : "Zlowout"};
         5'b10100: seq = {seq, "Gra Rout PCin"};
         default:  seq = {seq, ""};
      endcase
   endfunction

   task automatic check(string tag, logic [24:0] exp);
      logic [24:0] obs = observed();
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic reset_cycles(int n);
      rst_n = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         check("reset", '0);
      end
      rst_n = 1'b1;
   endtask

   // Run one instruction; abort_at >= 0 asserts reset right after that step.
   task automatic exec_instr(logic [31:0] word, bit con, int abort_at);
      logic [4:0] opc = word[31:27];
      build_seq(opc, con);
      for (int t = 0; t < seq.size(); t++) begin
         @(posedge clk); #1;
         if (t == 0) begin
            ir     = word;
            con_ff = con;
         end
         check($sformatf("op%b_con%0d_t%0d", opc, con, t), mask_of(seq[t]) | mask_of("run"));
         if (t == abort_at) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            check($sformatf("op%b_abort", opc), '0);
            rst_n = 1'b1;
            return;
         end
      end
      if (opc == 5'b11011) begin
         for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check($sformatf("halt_idle%0d", k), '0);
         end
      end
   endtask

   logic [4:0] defined_ops [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                     5'b00101, 5'b00110, 5'b01100, 5'b10010, 5'b10100,
                                     5'b11010};

   initial begin
      logic [4:0] opc;
      reset_cycles(2);
      exec_instr({5'd0, 4'd1, 4'd0, 4'd0, 15'd85}, 1'b0, -1);
      exec_instr({5'd1, 4'd2, 4'd1, 4'd0, 15'd35}, 1'b0, -1);
      exec_instr({5'd3, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b0, -1);
      exec_instr({5'b10010, 27'h0123456}, 1'b0, -1);
      exec_instr({5'b10010, 27'h0123456}, 1'b1, -1);
      exec_instr({5'b11111, 27'h7ffffff}, 1'b1, -1);
      exec_instr({5'b00100, 27'h0000abc}, 1'b0, -1);
      exec_instr({5'b00101, 27'h0000abc}, 1'b0, -1);
      exec_instr({5'b00110, 27'h0000abc}, 1'b0, -1);
      exec_instr({5'b01100, 27'h0000abc}, 1'b0, -1);
      exec_instr({5'b10100, 27'h0000abc}, 1'b0, -1);
      exec_instr({5'b00010, 27'h0000abc}, 1'b0, -1);
      exec_instr({5'b11010, 27'h0000abc}, 1'b0, -1);
      exec_instr({5'b00010, 27'h1234567}, 1'b0, 5);
      exec_instr({5'b00000, 27'h0000055}, 1'b1, -1);
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) opc = 5'($urandom);
         else opc = defined_ops[$urandom_range(0, 10)];
         if (opc == 5'b11011) opc = 5'b11010;
         exec_instr({opc, 27'($urandom)}, 1'($urandom), -1);
      end
      exec_instr({5'b11011, 27'h0000000}, 1'b0, -1);
      reset_cycles(1);
      exec_instr({5'b10010, 27'h0000001}, 1'b1, -1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
